// File: rtl/strhw_block_sequencer.sv
// Streebog (GOST R 34.11-2012) block sequencer.
// Keeps the chaining state h, the bit counter N and the checksum Sigma, feeds the
// compression engine one g-call per block, pads the final block, then runs the two
// finalisation passes g_0(h,N) and g_0(h,Sigma) before presenting the digest.
module strhw_block_sequencer #(
   parameter logic [511:0] IV_512 = 512'h0,
   parameter logic [511:0] IV_256 = {64{8'h01}}
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic         hash_size_i,
   input  logic         blk_valid_i,
   output logic         blk_ready_o,
   input  logic [511:0] blk_data_i,
   input  logic         blk_last_i,
   input  logic [5:0]   blk_bytes_i,
   output logic         eng_start_o,
   output logic [511:0] eng_h_o,
   output logic [511:0] eng_n_o,
   output logic [511:0] eng_m_o,
   input  logic         eng_done_i,
   input  logic [511:0] eng_h_i,
   output logic         busy_o,
   output logic         hash_valid_o,
   output logic [511:0] hash_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_BLK,
      S_COMPRESS,
      S_FIN_N,
      S_FIN_SIGMA,
      S_DONE
   } state_t;

   state_t       r_state;
   state_t       w_state_next;

   logic [511:0] r_h;
   logic [511:0] r_n;
   logic [511:0] r_sigma;
   logic [9:0]   r_len;        // bit length of the block in flight (0..512)
   logic         r_last;       // block in flight is the final one
   logic         r_size;       // 1 = 256-bit digest
   logic         r_eng_start;
   logic [511:0] r_eng_h;
   logic [511:0] r_eng_n;
   logic [511:0] r_eng_m;
   logic [511:0] r_hash;
   logic         r_hash_valid;

   logic         w_done;
   logic [511:0] w_pad_m;
   logic [511:0] w_blk_m;
   logic [9:0]   w_blk_len;
   logic [511:0] w_n_plus_len;

   // A done pulse coinciding with our own start pulse belongs to no g-call we issued.
   assign w_done = eng_done_i && !r_eng_start;

   // Final-block padding: keep bytes below blk_bytes_i, put 0x01 at byte blk_bytes_i,
   // clear everything above it.
   genvar gi;
   generate
      for (gi = 0; gi < 64; gi++) begin : g_pad
         assign w_pad_m[8*gi +: 8] = (6'(gi) < blk_bytes_i)  ? blk_data_i[8*gi +: 8] :
                                     (6'(gi) == blk_bytes_i) ? 8'h01 : 8'h00;
      end
   endgenerate

   assign w_blk_m      = blk_last_i ? w_pad_m : blk_data_i;
   assign w_blk_len    = blk_last_i ? {1'b0, blk_bytes_i, 3'b000} : 10'd512;
   assign w_n_plus_len = r_n + {502'd0, r_len};

   assign eng_start_o  = r_eng_start;
   assign eng_h_o      = r_eng_h;
   assign eng_n_o      = r_eng_n;
   assign eng_m_o      = r_eng_m;
   assign hash_valid_o = r_hash_valid;
   assign hash_o       = r_hash;

   // Next-state decode plus the state-derived handshake/status outputs.
   always_comb begin
      w_state_next = r_state;
      blk_ready_o  = 1'b0;
      busy_o       = 1'b1;
      case (r_state)
         S_IDLE, S_DONE: begin
            busy_o = 1'b0;
            if (start_i) w_state_next = S_WAIT_BLK;
         end
         S_WAIT_BLK: begin
            blk_ready_o = 1'b1;
            if (blk_valid_i) w_state_next = S_COMPRESS;
         end
         S_COMPRESS: begin
            if (w_done) w_state_next = r_last ? S_FIN_N : S_WAIT_BLK;
         end
         S_FIN_N: begin
            if (w_done) w_state_next = S_FIN_SIGMA;
         end
         S_FIN_SIGMA: begin
            if (w_done) w_state_next = S_DONE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Algorithm state, engine operands and digest; operands only change on a launch.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_h          <= '0;
         r_n          <= '0;
         r_sigma      <= '0;
         r_len        <= '0;
         r_last       <= 1'b0;
         r_size       <= 1'b0;
         r_eng_start  <= 1'b0;
         r_eng_h      <= '0;
         r_eng_n      <= '0;
         r_eng_m      <= '0;
         r_hash       <= '0;
         r_hash_valid <= 1'b0;
      end else begin
         r_eng_start <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  r_h          <= hash_size_i ? IV_256 : IV_512;
                  r_n          <= '0;
                  r_sigma      <= '0;
                  r_size       <= hash_size_i;
                  r_hash       <= '0;
                  r_hash_valid <= 1'b0;
               end
            end
            S_WAIT_BLK: begin
               if (blk_valid_i) begin
                  r_eng_h     <= r_h;
                  r_eng_n     <= r_n;
                  r_eng_m     <= w_blk_m;
                  r_len       <= w_blk_len;
                  r_last      <= blk_last_i;
                  r_eng_start <= 1'b1;
               end
            end
            S_COMPRESS: begin
               if (w_done) begin
                  r_h     <= eng_h_i;
                  r_n     <= w_n_plus_len;
                  r_sigma <= r_sigma + r_eng_m;
                  if (r_last) begin
                     r_eng_h     <= eng_h_i;
                     r_eng_n     <= '0;
                     r_eng_m     <= w_n_plus_len;
                     r_eng_start <= 1'b1;
                  end
               end
            end
            S_FIN_N: begin
               if (w_done) begin
                  r_h         <= eng_h_i;
                  r_eng_h     <= eng_h_i;
                  r_eng_n     <= '0;
                  r_eng_m     <= r_sigma;
                  r_eng_start <= 1'b1;
               end
            end
            S_FIN_SIGMA: begin
               if (w_done) begin
                  r_h          <= eng_h_i;
                  r_hash       <= r_size ? {256'h0, eng_h_i[511:256]} : eng_h_i;
                  r_hash_valid <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_strhw_block_sequencer.sv
// Bench for strhw_block_sequencer with an XOR stub engine (h' = h ^ m, done 3 cycles
// after start). Expected launches and digests come from a message-level model.
module tb_strhw_block_sequencer;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         start_i = 1'b0;
   logic         hash_size_i = 1'b0;
   logic         blk_valid_i = 1'b0;
   logic         blk_ready_o;
   logic [511:0] blk_data_i = '0;
   logic         blk_last_i = 1'b0;
   logic [5:0]   blk_bytes_i = '0;
   logic         eng_start_o;
   logic [511:0] eng_h_o, eng_n_o, eng_m_o;
   logic         eng_done_i;
   logic [511:0] eng_h_i;
   logic         busy_o, hash_valid_o;
   logic [511:0] hash_o;

   always #5 clk_i = ~clk_i;

   strhw_block_sequencer dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .hash_size_i(hash_size_i),
      .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_data_i(blk_data_i),
      .blk_last_i(blk_last_i), .blk_bytes_i(blk_bytes_i), .eng_start_o(eng_start_o),
      .eng_h_o(eng_h_o), .eng_n_o(eng_n_o), .eng_m_o(eng_m_o), .eng_done_i(eng_done_i),
      .eng_h_i(eng_h_i), .busy_o(busy_o), .hash_valid_o(hash_valid_o), .hash_o(hash_o)
   );

   int checks = 0;
   int errors = 0;
   int msg_no = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // ---------------- stub engine + launch log ----------------
   logic         stub_done = 1'b0;
   logic [511:0] stub_val = '0;
   int           stub_cnt = 0;
   logic         inj_done = 1'b0;
   logic [511:0] inj_val = '0;
   logic [511:0] lh_q[$], ln_q[$], lm_q[$];

   assign eng_done_i = stub_done | inj_done;
   assign eng_h_i    = inj_done ? inj_val : stub_val;

   always @(posedge clk_i) begin
      if (rst_i) begin
         stub_cnt  <= 0;
         stub_done <= 1'b0;
      end else begin
         stub_done <= 1'b0;
         if (eng_start_o) begin
            stub_cnt <= 3;
            stub_val <= eng_h_o ^ eng_m_o;
            lh_q.push_back(eng_h_o);
            ln_q.push_back(eng_n_o);
            lm_q.push_back(eng_m_o);
         end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) stub_done <= 1'b1;
         end
      end
   end

   // ---------------- latency monitor ----------------
   logic prev_acc = 1'b0, prev_done = 1'b0, prev_start = 1'b0, prev_hv = 1'b0;
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (eng_start_o) begin
            check("start_latency", {511'd0, prev_acc | prev_done}, 512'd1);
            check("start_pulse", {511'd0, prev_start}, 512'd0);
         end
         if (hash_valid_o && !prev_hv) check("hv_latency", {511'd0, prev_done}, 512'd1);
      end
      prev_acc   <= blk_valid_i & blk_ready_o;
      prev_done  <= eng_done_i;
      prev_start <= eng_start_o;
      prev_hv    <= hash_valid_o;
   end

   // ---------------- reference model ----------------
   logic [511:0] blk_q[$];
   logic [511:0] exp_h[$], exp_n[$], exp_m[$];
   logic [511:0] exp_hash;

   function automatic logic [511:0] pad_ref(input logic [511:0] d, input int nb);
      logic [511:0] one;
      logic [511:0] mask;
      one  = 512'h1;
      mask = (one << (8 * nb)) - one;
      return (d & mask) | (one << (8 * nb));
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   task automatic model(input bit size, input int nb);
      logic [511:0] h, n, s, m, len_v;
      exp_h.delete(); exp_n.delete(); exp_m.delete();
      h = size ? {64{8'h01}} : 512'h0;
      n = '0;
      s = '0;
      for (int i = 0; i < blk_q.size(); i++) begin
         if (i == blk_q.size() - 1) begin
            m     = pad_ref(blk_q[i], nb);
            len_v = 512'(8 * nb);
         end else begin
            m     = blk_q[i];
            len_v = 512'd512;
         end
         exp_h.push_back(h); exp_n.push_back(n); exp_m.push_back(m);
         h = h ^ m;
         n = n + len_v;
         s = s + m;
      end
      exp_h.push_back(h); exp_n.push_back('0); exp_m.push_back(n);
      h = h ^ n;
      exp_h.push_back(h); exp_n.push_back('0); exp_m.push_back(s);
      h = h ^ s;
      exp_hash = size ? {256'h0, h[511:256]} : h;
   endtask

   // Runs one message from blk_q through the DUT and compares against the model.
   task automatic send_msg(input bit size, input int nb, input bit start_glitch, input bit done_glitch);
      int n;
      int t;
      n = blk_q.size();
      model(size, nb);
      lh_q.delete(); ln_q.delete(); lm_q.delete();
      start_i = 1'b1; hash_size_i = size;
      tick();
      start_i = 1'b0;
      check("hv_cleared", {511'd0, hash_valid_o}, 512'd0);
      check("hash_cleared", hash_o, 512'd0);
      for (int i = 0; i < n; i++) begin
         blk_data_i  = blk_q[i];
         blk_last_i  = (i == n - 1);
         blk_bytes_i = (i == n - 1) ? 6'(nb) : 6'($urandom);
         blk_valid_i = 1'b1;
         t = 0;
         while (!blk_ready_o && t < 100) begin tick(); t++; end
         if (!blk_ready_o) begin
            check("ready_timeout", 512'd0, 512'd1);
            blk_valid_i = 1'b0;
            return;
         end
         tick();
         // valid stays asserted while the engine runs; it must not be consumed
         if (start_glitch && i == 0) begin
            start_i = 1'b1; hash_size_i = ~size;
            tick();
            start_i = 1'b0; hash_size_i = size;
            check("busy_after_start_glitch", {511'd0, busy_o}, 512'd1);
         end
         if (done_glitch && i == 0 && n > 1) begin
            blk_valid_i = 1'b0;
            t = 0;
            while (!blk_ready_o && t < 100) begin tick(); t++; end
            inj_val = rand512(); inj_done = 1'b1;
            tick();
            inj_done = 1'b0;
         end
      end
      blk_valid_i = 1'b0;
      blk_last_i  = 1'b0;
      t = 0;
      while (!hash_valid_o && t < 200) begin tick(); t++; end
      check("hash_valid", {511'd0, hash_valid_o}, 512'd1);
      check("launch_count", 512'(lm_q.size()), 512'(exp_m.size()));
      for (int i = 0; i < lm_q.size() && i < exp_m.size(); i++) begin
         check($sformatf("launch%0d_h", i), lh_q[i], exp_h[i]);
         check($sformatf("launch%0d_n", i), ln_q[i], exp_n[i]);
         check($sformatf("launch%0d_m", i), lm_q[i], exp_m[i]);
      end
      check("hash", hash_o, exp_hash);
      tick(); tick();
      check("hv_held", {511'd0, hash_valid_o}, 512'd1);
      check("busy_done", {511'd0, busy_o}, 512'd0);
      check("ready_done", {511'd0, blk_ready_o}, 512'd0);
      $display("msg %0d size=%0d blocks=%0d bytes=%0d sg=%0d dg=%0d hash=%h",
               msg_no, size, n, nb, start_glitch, done_glitch, hash_o);
      msg_no++;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, {511'd0, busy_o}, 512'd0);
      check({tag, "_ready"}, {511'd0, blk_ready_o}, 512'd0);
      check({tag, "_start"}, {511'd0, eng_start_o}, 512'd0);
      check({tag, "_eng_h"}, eng_h_o, 512'd0);
      check({tag, "_eng_n"}, eng_n_o, 512'd0);
      check({tag, "_eng_m"}, eng_m_o, 512'd0);
      check({tag, "_hv"}, {511'd0, hash_valid_o}, 512'd0);
      check({tag, "_hash"}, hash_o, 512'd0);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      bit           size;
      int           bytes;
      logic [511:0] data;
      logic [511:0] exp_m;
      logic [511:0] exp_h;
      logic [511:0] exp_hash;
   } vec_t;

   vec_t vt[5];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [511:0] a, b, c;
      int t;

      vt[0] = '{1'b0, 0,  512'hDEADBEEF_CAFEF00D, 512'h1, 512'h0, 512'h0};
      vt[1] = '{1'b0, 3,  512'h1234_56AABBCC, 512'h01AABBCC, 512'h0, 512'd24};
      vt[2] = '{1'b1, 5,  {512{1'b1}}, 512'h01FFFFFFFFFF, {64{8'h01}}, {256'h0, {32{8'h01}}}};
      vt[3] = '{1'b0, 63, {512{1'b1}}, {8'h01, {63{8'hFF}}}, 512'h0, 512'd504};
      vt[4] = '{1'b1, 1,  512'h5A5A, 512'h015A, {64{8'h01}}, {256'h0, {32{8'h01}}}};

      // reset state
      rst_i = 1'b1;
      tick(); tick(); tick();
      check_idle_outputs("reset");
      rst_i = 1'b0;
      tick();
      check_idle_outputs("post_reset");

      // single-block table: padding, IV selection, digest = IV ^ bit length
      for (int i = 0; i < 5; i++) begin
         blk_q.delete();
         blk_q.push_back(vt[i].data);
         send_msg(vt[i].size, vt[i].bytes, 1'b0, 1'b0);
         if (lm_q.size() == 3) begin
            check($sformatf("tbl%0d_h0", i), lh_q[0], vt[i].exp_h);
            check($sformatf("tbl%0d_n0", i), ln_q[0], 512'h0);
            check($sformatf("tbl%0d_m0", i), lm_q[0], vt[i].exp_m);
            check($sformatf("tbl%0d_m1", i), lm_q[1], 512'(8 * vt[i].bytes));
            check($sformatf("tbl%0d_m2", i), lm_q[2], vt[i].exp_m);
         end
         check($sformatf("tbl%0d_hash", i), hash_o, vt[i].exp_hash);
      end

      // two full blocks plus a 3-byte tail
      a = rand512(); b = rand512(); c = rand512();
      c[23:0] = 24'hAABBCC;
      blk_q.delete();
      blk_q.push_back(a); blk_q.push_back(b); blk_q.push_back(c);
      send_msg(1'b0, 3, 1'b0, 1'b0);
      if (lm_q.size() == 5) begin
         check("seq_n0", ln_q[0], 512'd0);
         check("seq_n1", ln_q[1], 512'd512);
         check("seq_n2", ln_q[2], 512'd1024);
         check("seq_m2", lm_q[2], 512'h01AABBCC);
         check("seq_fin_n_m", lm_q[3], 512'd1048);
         check("seq_fin_sigma_m", lm_q[4], a + b + 512'h01AABBCC);
      end

      // protocol corners: start in COMPRESS, stray done in WAIT_BLK
      blk_q.delete();
      blk_q.push_back(rand512()); blk_q.push_back(rand512());
      send_msg(1'b0, 17, 1'b1, 1'b0);
      blk_q.delete();
      blk_q.push_back(rand512()); blk_q.push_back(rand512()); blk_q.push_back(rand512());
      send_msg(1'b1, 40, 1'b1, 1'b1);

      // randomized messages
      for (int r = 0; r < 20; r++) begin
         int nfull;
         nfull = $urandom_range(0, 3);
         blk_q.delete();
         for (int k = 0; k <= nfull; k++) blk_q.push_back(rand512());
         send_msg(1'($urandom), $urandom_range(0, 63), 1'($urandom), 1'($urandom));
      end

      // reset during FIN_N aborts, then a fresh message runs normally
      lh_q.delete(); ln_q.delete(); lm_q.delete();
      start_i = 1'b1; hash_size_i = 1'b0;
      tick();
      start_i = 1'b0;
      blk_data_i = '0; blk_last_i = 1'b1; blk_bytes_i = '0; blk_valid_i = 1'b1;
      t = 0;
      while (!blk_ready_o && t < 100) begin tick(); t++; end
      tick();
      blk_valid_i = 1'b0; blk_last_i = 1'b0;
      t = 0;
      while (lm_q.size() < 2 && t < 100) begin tick(); t++; end
      check("fin_n_reached", 512'(lm_q.size()), 512'd2);
      check("fin_n_busy", {511'd0, busy_o}, 512'd1);
      rst_i = 1'b1;
      tick();
      check_idle_outputs("mid_reset");
      rst_i = 1'b0;
      tick();
      blk_q.delete();
      blk_q.push_back(vt[0].data);
      send_msg(1'b0, 0, 1'b0, 1'b0);
      if (lm_q.size() == 3) check("after_reset_m0", lm_q[0], 512'h1);
      check("after_reset_hash", hash_o, 512'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
